// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and
// drives memory strobes plus PC, IR, ALU and register-file controls.
module mc_control_fsm #(
  parameter int unsigned CNT_W        = 32,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [31:0]      instr,
  input  logic             zero,
  output logic [3:0]       estado,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             branch,
  output logic             regwrite,
  output logic             memtoreg,
  output logic             memread,
  output logic             memwrite,
  output logic             is_lb,
  output logic             is_sb,
  output logic [1:0]       alusrc_b,
  output logic [1:0]       aluop,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'b0000,
    DECODE   = 4'b0001,
    MEMADR   = 4'b0010,
    MEMREAD  = 4'b0011,
    EXEC_R   = 4'b0100,
    EXEC_I   = 4'b0101,
    MEMWRITE = 4'b0110,
    MEMWB    = 4'b0111,
    ALUWB    = 4'b1000,
    BRANCH   = 4'b1001,
    HALT     = 4'b1010
  } state_t;

  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       is_lb;
    logic       is_sb;
    logic [1:0] alusrc_b;
    logic [1:0] aluop;
    logic       halted;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t            state;
  state_t            nxt;
  logic [2:0]        f3_q;
  logic [2:0]        nf3;
  logic [6:0]        op_q;
  logic [6:0]        nop;
  ctrl_t             ctrl_q;
  logic [CNT_W-1:0]  cnt_q;

  // The zero flag only qualifies the PC load outside this block.
  logic unused_zero;
  assign unused_zero = zero;

  function automatic ctrl_t ctrl_of(input state_t s, input logic [2:0] f3);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite  = 1'b1;
        c.pcwrite  = 1'b1;
        c.alusrc_b = 2'b01;
        c.aluop    = 2'b00;
      end
      MEMADR: c.alusrc_b = 2'b10;
      MEMREAD: begin
        c.memread = 1'b1;
        c.is_lb   = (f3 == 3'b000);
      end
      // Read strobe held through writeback so the memory stage keeps its data.
      MEMWB: begin
        c.memread  = 1'b1;
        c.is_lb    = (f3 == 3'b000);
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      MEMWRITE: begin
        c.memwrite = 1'b1;
        c.is_sb    = (f3 == 3'b000);
      end
      EXEC_R: c.aluop = 2'b10;
      EXEC_I: begin
        c.alusrc_b = 2'b10;
        c.aluop    = 2'b10;
      end
      ALUWB:  c.regwrite = 1'b1;
      BRANCH: begin
        c.branch = 1'b1;
        c.aluop  = 2'b01;
      end
      HALT:   c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = FETCH;
    nf3 = f3_q;
    nop = op_q;
    case (state)
      FETCH:  nxt = DECODE;
      DECODE: begin
        nf3 = instr[14:12];
        nop = instr[6:0];
        if (HALT_ON_ZERO && instr == '0) begin
          nxt = HALT;
        end else begin
          case (instr[6:0])
            OP_LOAD, OP_STORE:
              nxt = (instr[14:12] == 3'b000 || instr[14:12] == 3'b010) ? MEMADR : HALT;
            OP_R:      nxt = EXEC_R;
            OP_I:      nxt = EXEC_I;
            OP_BRANCH: nxt = BRANCH;
            default:   nxt = HALT;
          endcase
        end
      end
      MEMADR:   nxt = (op_q == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  nxt = MEMWB;
      MEMWB:    nxt = FETCH;
      MEMWRITE: nxt = FETCH;
      EXEC_R:   nxt = ALUWB;
      EXEC_I:   nxt = ALUWB;
      ALUWB:    nxt = FETCH;
      BRANCH:   nxt = FETCH;
      HALT:     nxt = HALT;
      default:  nxt = FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FETCH;
      f3_q   <= '0;
      op_q   <= '0;
      cnt_q  <= '0;
      ctrl_q <= ctrl_of(FETCH, 3'b000);
    end else if (enable) begin
      state  <= nxt;
      f3_q   <= nf3;
      op_q   <= nop;
      ctrl_q <= ctrl_of(nxt, nf3);
      if (state == FETCH) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign estado      = state;
  assign irwrite     = ctrl_q.irwrite;
  assign pcwrite     = ctrl_q.pcwrite;
  assign branch      = ctrl_q.branch;
  assign regwrite    = ctrl_q.regwrite;
  assign memtoreg    = ctrl_q.memtoreg;
  assign memread     = ctrl_q.memread;
  assign memwrite    = ctrl_q.memwrite;
  assign is_lb       = ctrl_q.is_lb;
  assign is_sb       = ctrl_q.is_sb;
  assign alusrc_b    = ctrl_q.alusrc_b;
  assign aluop       = ctrl_q.aluop;
  assign halted      = ctrl_q.halted;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: expected state/control words are queued
// as each instruction is applied and compared once per cycle on the falling edge.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] instr;
  logic        zero;
  logic [3:0]  estado;
  logic        irwrite, pcwrite, branch, regwrite, memtoreg;
  logic        memread, memwrite, is_lb, is_sb, halted;
  logic [1:0]  alusrc_b, aluop;
  logic [31:0] instr_count;

  int checks   = 0;
  int failures = 0;
  int unsigned model_cnt = 0;
  logic [17:0] sb_q[$];

  mc_control_fsm #(.CNT_W(32), .HALT_ON_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .instr(instr), .zero(zero),
    .estado(estado), .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
    .regwrite(regwrite), .memtoreg(memtoreg), .memread(memread),
    .memwrite(memwrite), .is_lb(is_lb), .is_sb(is_sb), .alusrc_b(alusrc_b),
    .aluop(aluop), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] exp_ctrl(input logic [3:0] st, input logic [2:0] f3);
    logic iw, pw, br, rw, mt, mr, mw, lb, sb, h;
    logic [1:0] bs, op;
    {iw, pw, br, rw, mt, mr, mw, lb, sb, h} = '0;
    bs = 2'b00;
    op = 2'b00;
    case (st)
      4'h0: begin iw = 1'b1; pw = 1'b1; bs = 2'b01; end
      4'h2: bs = 2'b10;
      4'h3: begin mr = 1'b1; lb = (f3 == 3'b000); end
      4'h7: begin mr = 1'b1; lb = (f3 == 3'b000); rw = 1'b1; mt = 1'b1; end
      4'h6: begin mw = 1'b1; sb = (f3 == 3'b000); end
      4'h4: op = 2'b10;
      4'h5: begin bs = 2'b10; op = 2'b10; end
      4'h8: rw = 1'b1;
      4'h9: begin br = 1'b1; op = 2'b01; end
      4'hA: h = 1'b1;
      default: ;
    endcase
    return {iw, pw, br, rw, mt, mr, mw, lb, sb, bs, op, h};
  endfunction

  task automatic push(input logic [3:0] st, input logic [2:0] f3);
    sb_q.push_back({st, exp_ctrl(st, f3)});
  endtask

  task automatic check_out(input string tag);
    logic [17:0] e;
    logic [17:0] o;
    e = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
    o = {estado, irwrite, pcwrite, branch, regwrite, memtoreg, memread, memwrite,
         is_lb, is_sb, alusrc_b, aluop, halted};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_count(input string tag);
    checks++;
    assert (instr_count === model_cnt) else begin
      failures++;
      $error("FAIL %s: instr_count observed=%0d expected=%0d", tag, instr_count, model_cnt);
    end
  endtask

  // Starts on a falling edge in FETCH; seq lists n state codes, first in the top nibble.
  task automatic run_seq(input string tag, input logic [31:0] iw,
                         input logic [23:0] seq, input int unsigned n);
    instr = iw;
    for (int unsigned k = 0; k < n; k++) push(seq[4*(5-k) +: 4], iw[14:12]);
    for (int unsigned k = 0; k < n; k++) begin
      check_out($sformatf("%s[%0d]", tag, k));
      @(negedge clk);
    end
    model_cnt++;
    check_count({tag, "_cnt"});
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    push(4'h0, 3'b000);
    check_out(tag);
    model_cnt = 0;
    check_count({tag, "_cnt"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b1;
    enable = 1'b1;
    instr  = '0;
    zero   = 1'b0;
    #1;
    do_reset("reset");
    push(4'h0, 3'b000);
    check_out("reset_fetch");

    run_seq("lw",   32'h00402083, 24'h012370, 5);
    run_seq("lb",   32'h00400083, 24'h012370, 5);
    run_seq("sb",   32'h002000A3, 24'h012600, 4);
    run_seq("add",  32'h002081B3, 24'h014800, 4);
    run_seq("addi", 32'h00100093, 24'h015800, 4);
    run_seq("beq",  32'h00000463, 24'h019000, 3);

    // Freeze in MEMWRITE for three edges, then resume.
    run_seq("sw", 32'h00202223, 24'h012000, 3);
    push(4'h6, 3'b010);
    check_out("sw_memwrite");
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      push(4'h6, 3'b010);
      check_out("sw_frozen");
    end
    check_count("frozen_cnt");
    enable = 1'b1;
    @(negedge clk);
    push(4'h0, 3'b000);
    check_out("sw_refetch");

    // Asynchronous reset while in MEMREAD.
    run_seq("lw_rst", 32'h00402083, 24'h012000, 3);
    push(4'h3, 3'b010);
    check_out("memread_pre");
    #2;
    do_reset("async_rst");

    // Illegal instruction halts and stays halted.
    run_seq("ill", 32'hFFFFFFFF, 24'h01A000, 3);
    repeat (10) begin
      push(4'hA, 3'b111);
      check_out("halt_sticky");
      @(negedge clk);
    end
    check_count("halt_cnt");
    do_reset("halt_rst");

    // Load with an unsupported width and the all-zero word both halt.
    run_seq("lh", 32'h00401083, 24'h01A000, 3);
    do_reset("lh_rst");
    run_seq("zero", 32'h00000000, 24'h01A000, 3);
    do_reset("zero_rst");
    push(4'h0, 3'b000);
    check_out("final_fetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
